// File: rtl/sync_mem_port_arb_pkg.sv
// Shared types and helpers for the memory-port round-robin arbiter.
// Perf counters are enabled by SYNC_MEM_PORT_ARB_PERF_CNT_EN.
package sync_mem_port_arb_pkg;

  localparam int PERF_CNT_WIDTH = 16;
  localparam int MAX_ID_WIDTH   = 4;

  typedef struct packed {
    logic                    valid;
    logic [MAX_ID_WIDTH-1:0] id;
  } rsp_tag_t;

  function automatic int unsigned next_ptr(
    input int unsigned idx,
    input int unsigned n
  );
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/sync_mem_port_arb_rr.sv
// Round-robin arbiter: searches from its pointer, wraps, picks first
// requester; pointer moves past the winner when advance is asserted.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_advance,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);
  import sync_mem_port_arb_pkg::*;

  logic [IDX_W-1:0] r_ptr;

  always_comb begin : search
    logic [IDX_W:0] j;
    j       = '0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = {1'b0, r_ptr} + (IDX_W+1)'(k);
      if (j >= (IDX_W+1)'(NUM_REQ))
        j = j - (IDX_W+1)'(NUM_REQ);
      if (!o_any && i_req[j[IDX_W-1:0]]) begin
        o_any                  = 1'b1;
        o_grant[j[IDX_W-1:0]]  = 1'b1;
        o_idx                  = j[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_ptr <= '0;
    else if (i_advance && o_any)
      r_ptr <= IDX_W'(next_ptr(32'(o_idx),
                               32'(NUM_REQ)));
  end

endmodule

// File: rtl/sync_mem_port_arb.sv
// Shares one 1W/1R sync memory among NUM_REQ clients, reads and
// writes arbitrated independently. Option: SYNC_MEM_PORT_ARB_PERF_CNT_EN.
module sync_mem_port_arb #(
  parameter  int NUM_REQ    = 4,
  parameter  int ADDR_WIDTH = 8,
  parameter  int DATA_WIDTH = 8,
  localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0]                  req_we,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic                                rsp_valid,
  output logic [ID_WIDTH-1:0]                 rsp_id,
  output logic [DATA_WIDTH-1:0]               rsp_data,
  output logic                                mem_wr_en,
  output logic [ADDR_WIDTH-1:0]               mem_wr_addr,
  output logic [DATA_WIDTH-1:0]               mem_wr_data,
  output logic [ADDR_WIDTH-1:0]               mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]               mem_rd_data
`ifdef SYNC_MEM_PORT_ARB_PERF_CNT_EN
  ,
  output logic [NUM_REQ-1:0][15:0]            perf_grant_cnt,
  output logic [15:0]                         perf_conflict_cnt
`endif
);
  import sync_mem_port_arb_pkg::*;

  logic [NUM_REQ-1:0]  w_rd_cand;
  logic [NUM_REQ-1:0]  w_wr_cand;
  logic [NUM_REQ-1:0]  w_rd_grant;
  logic [NUM_REQ-1:0]  w_wr_grant;
  logic [ID_WIDTH-1:0] w_rd_idx;
  logic [ID_WIDTH-1:0] w_wr_idx;
  logic                w_rd_any;
  logic                w_wr_any;
  rsp_tag_t            r_rsp;
  logic                w_unused;

  // Nothing is granted while in reset.
  assign w_rd_cand = req_valid & ~req_we & {NUM_REQ{~rst}};
  assign w_wr_cand = req_valid &  req_we & {NUM_REQ{~rst}};

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (w_rd_cand),
    .i_advance (w_rd_any),
    .o_grant   (w_rd_grant),
    .o_idx     (w_rd_idx),
    .o_any     (w_rd_any)
  );

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (w_wr_cand),
    .i_advance (w_wr_any),
    .o_grant   (w_wr_grant),
    .o_idx     (w_wr_idx),
    .o_any     (w_wr_any)
  );

  assign req_ready = w_rd_grant | w_wr_grant;

  always_comb begin
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    mem_rd_addr = '0;
    if (w_wr_any) begin
      mem_wr_en   = 1'b1;
      mem_wr_addr = req_addr[w_wr_idx];
      mem_wr_data = req_wdata[w_wr_idx];
    end
    if (w_rd_any)
      mem_rd_addr = req_addr[w_rd_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp <= '0;
    end else begin
      r_rsp.valid <= w_rd_any;
      r_rsp.id    <= MAX_ID_WIDTH'(w_rd_idx);
    end
  end

  // Gating with rst drops a response already in flight.
  assign rsp_valid = r_rsp.valid & ~rst;
  assign rsp_id    = rst ? '0 : r_rsp.id[ID_WIDTH-1:0];
  assign rsp_data  = mem_rd_data;
  assign w_unused  = ^r_rsp.id;

`ifdef SYNC_MEM_PORT_ARB_PERF_CNT_EN
  logic [NUM_REQ-1:0][PERF_CNT_WIDTH-1:0] r_grant_cnt;
  logic [PERF_CNT_WIDTH-1:0]              r_conflict_cnt;
  logic [NUM_REQ-1:0]                     w_rd_deny;
  logic [NUM_REQ-1:0]                     w_wr_deny;
  logic                                   w_conflict;

  assign w_rd_deny  = w_rd_cand & ~w_rd_grant;
  assign w_wr_deny  = w_wr_cand & ~w_wr_grant;
  // x & (x-1) is nonzero exactly when two or more bits are set.
  assign w_conflict = |(w_rd_deny & (w_rd_deny - 1'b1)) |
                      |(w_wr_deny & (w_wr_deny - 1'b1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant_cnt    <= '0;
      r_conflict_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (req_ready[i] && r_grant_cnt[i] != '1)
          r_grant_cnt[i] <= r_grant_cnt[i] + 1'b1;
      if (w_conflict && r_conflict_cnt != '1)
        r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end

  assign perf_grant_cnt    = r_grant_cnt;
  assign perf_conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_sync_mem_port_arb.sv
// Scoreboard bench for sync_mem_port_arb with a behavioural memory.
// Saturation test runs when SYNC_MEM_PORT_ARB_PERF_CNT_EN is defined.
module tb_sync_mem_port_arb;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]         req_valid, req_we, req_ready;
  logic [N-1:0][AW-1:0] req_addr;
  logic [N-1:0][DW-1:0] req_wdata;
  logic                 rsp_valid;
  logic [IW-1:0]        rsp_id;
  logic [DW-1:0]        rsp_data;
  logic                 mem_wr_en;
  logic [AW-1:0]        mem_wr_addr, mem_rd_addr;
  logic [DW-1:0]        mem_wr_data, mem_rd_data;
`ifdef SYNC_MEM_PORT_ARB_PERF_CNT_EN
  logic [N-1:0][15:0]   perf_grant_cnt;
  logic [15:0]          perf_conflict_cnt;
`endif

  sync_mem_port_arb #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data)
`ifdef SYNC_MEM_PORT_ARB_PERF_CNT_EN
    ,
    .perf_grant_cnt    (perf_grant_cnt),
    .perf_conflict_cnt (perf_conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // External memory: registered read, write-to-read forwarding.
  logic [DW-1:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    mem_rd_data <= (mem_wr_en && mem_wr_addr == mem_rd_addr)
                   ? mem_wr_data : mem[mem_rd_addr];
  end

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int id;
    int data;
  } exp_t;
  exp_t q[$];

  int           rptr = 0;
  int           wptr = 0;
  int           shadow [256];
  logic [N-1:0] act_ready;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic int rr_pick(input int ptr, input logic [N-1:0] c);
    for (int k = 0; k < N; k++)
      if (c[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // One cycle: check combinational outputs against the model,
  // advance the model, return just after the next rising edge.
  task automatic step();
    int           er, ew;
    logic [N-1:0] exp_rdy;
    logic [16:0]  exp_wr;
    logic [7:0]   exp_ra;
    @(negedge clk);
    er = -1; ew = -1; exp_rdy = '0; exp_wr = '0; exp_ra = '0;
    if (!rst) begin
      er = rr_pick(rptr, req_valid & ~req_we);
      ew = rr_pick(wptr, req_valid & req_we);
    end
    if (er >= 0) begin
      exp_rdy[er] = 1'b1;
      exp_ra = req_addr[er];
    end
    if (ew >= 0) begin
      exp_rdy[ew] = 1'b1;
      exp_wr = {1'b1, req_addr[ew], req_wdata[ew]};
    end
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("mem_wr", 64'({mem_wr_en, mem_wr_addr, mem_wr_data}), 64'(exp_wr));
    chk("mem_rd_addr", 64'(mem_rd_addr), 64'(exp_ra));
    act_ready = req_ready;
    if (rst) begin
      rptr = 0;
      wptr = 0;
    end else begin
      if (ew >= 0) begin
        shadow[req_addr[ew]] = int'(req_wdata[ew]);
        wptr = (ew + 1) % N;
      end
      if (er >= 0) begin
        q.push_back('{cyc + 1, er, shadow[req_addr[er]]});
        rptr = (er + 1) % N;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Response monitor: independent of stimulus.
  initial begin
    forever begin
      bit   exp_p;
      exp_t e;
      @(negedge clk);
      exp_p = (q.size() > 0) && (q[0].cyc == cyc);
      if (rst) begin
        if (exp_p) void'(q.pop_front());
        chk("rsp_valid_in_rst", 64'(rsp_valid), 64'(0));
      end else begin
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_p));
        if (exp_p) begin
          e = q.pop_front();
          if (rsp_valid) begin
            chk("rsp_id", 64'(rsp_id), 64'(e.id));
            chk("rsp_data", 64'(rsp_data), 64'(e.data));
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    step();
    chk("reset_rsp", 64'({rsp_valid, rsp_id}), 64'(0));
    step();
    rst = 1'b0;

    // Write then read back the same address.
    req_valid = 4'b0001; req_we = 4'b0001;
    req_addr[0] = 8'h10; req_wdata[0] = 8'hA5;
    step();
    chk("t1_wr_grant", 64'(act_ready), 64'(4'b0001));
    req_valid = 4'b0010; req_we = '0; req_addr[1] = 8'h10;
    step();
    chk("t1_rd_grant", 64'(act_ready), 64'(4'b0010));
    req_valid = '0;
    chk("t1_rsp", 64'({rsp_valid, rsp_id, rsp_data}),
        64'({1'b1, 2'd1, 8'hA5}));
    step();

    rst = 1'b1; step(); rst = 1'b0;

    // Preload 0x00..0x03 with 0x11..0x44.
    for (int i = 0; i < N; i++) begin
      req_valid = '0; req_we = '0;
      req_valid[i] = 1'b1; req_we[i] = 1'b1;
      req_addr[i] = AW'(i); req_wdata[i] = DW'(8'h11 * (i + 1));
      step();
    end

    // All four read continuously.
    req_valid = '1; req_we = '0;
    for (int i = 0; i < N; i++) req_addr[i] = AW'(i);
    for (int k = 0; k < 8; k++) begin
      logic [3:0] eg;
      eg = 4'b0001 << (k % 4);
      step();
      chk("rr_rd_grant", 64'(act_ready), 64'(eg));
      chk("rr_rsp", 64'({rsp_id, rsp_data}),
          64'({IW'(k % 4), DW'(8'h11 * ((k % 4) + 1))}));
    end
    req_valid = '0;
    step();

    // Same-address write and read in one cycle.
    req_valid = 4'b1100; req_we = 4'b0100;
    req_addr[2] = 8'h20; req_wdata[2] = 8'h5A; req_addr[3] = 8'h20;
    step();
    chk("t3_grant", 64'(act_ready), 64'(4'b1100));
    req_valid = '0;
    chk("t3_rsp", 64'({rsp_valid, rsp_id, rsp_data}),
        64'({1'b1, 2'd3, 8'h5A}));
    step();

    // Two writers alternate.
    req_valid = 4'b0101; req_we = 4'b0101;
    req_addr[0] = 8'h30; req_wdata[0] = 8'h01;
    req_addr[2] = 8'h31; req_wdata[2] = 8'h02;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("alt_wr_grant", 64'(act_ready),
          64'((k % 2) ? 4'b0100 : 4'b0001));
    end
    req_valid = '0; req_we = '0;
    step();

    // Reset with a read in flight.
    req_valid = 4'b0010; req_addr[1] = 8'h10;
    step();
    req_valid = '0; rst = 1'b1;
    #1;
    chk("rst_drop", 64'(rsp_valid), 64'(0));
    step();
    rst = 1'b0;
    req_valid = '1; req_we = '0;
    step();
    chk("post_rst_grant", 64'(act_ready), 64'(4'b0001));
    req_valid = '0;
    step();

    // Random traffic; ungranted requests held stable.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || act_ready[i]) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          req_we[i]    = 1'($urandom_range(0, 1));
          req_addr[i]  = AW'(8'h40 + $urandom_range(0, 7));
          req_wdata[i] = DW'($urandom_range(0, 255));
        end
      end
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0; req_valid = '0;
    step();
    step();

`ifdef SYNC_MEM_PORT_ARB_PERF_CNT_EN
    rst = 1'b1; step(); rst = 1'b0;
    req_valid = 4'b0010; req_we = 4'b0010;
    req_addr[1] = 8'h50; req_wdata[1] = 8'h77;
    repeat (70000) step();
    req_valid = '0;
    chk("perf_sat", 64'(perf_grant_cnt[1]), 64'(16'hFFFF));
    chk("perf_idle", 64'(perf_grant_cnt[0]), 64'(0));
    step();
`endif

    chk("queue_empty", 64'(q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sync_mem_port_arb.md
Name: sync_mem_port_arb

Overview:
- Round-robin arbiter that shares one dual-port synchronous memory (1 write port, 1 read port, registered read, same-cycle write-to-read forwarding) between NUM_REQ requesters.
- Read and write classes are arbitrated independently, so up to one read grant and one write grant per cycle.
- Read data returns exactly one cycle after grant, tagged with the requester ID.
- Sits between the client blocks and the memory instance; the memory is external to this block.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ADDR_WIDTH, 8, memory address width.
- DATA_WIDTH, 8, memory data width.
- ID_WIDTH, $clog2(NUM_REQ), width of response tag (derived localparam).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  [NUM_REQ]  request present per requester
- req_we  in  [NUM_REQ]  1 = write, 0 = read
- req_addr  in  [NUM_REQ][ADDR_WIDTH]  request address
- req_wdata  in  [NUM_REQ][DATA_WIDTH]  write data
- req_ready  out  [NUM_REQ]  grant; request accepted when valid & ready
- rsp_valid  out  1  read data valid
- rsp_id  out  ID_WIDTH  requester receiving rsp_data
- rsp_data  out  DATA_WIDTH  read data
- mem_wr_en  out  1  to memory wr_en
- mem_wr_addr  out  ADDR_WIDTH  to memory write address
- mem_wr_data  out  DATA_WIDTH  to memory write data
- mem_rd_addr  out  ADDR_WIDTH  to memory read address
- mem_rd_data  in  DATA_WIDTH  from memory read data (registered, valid the cycle after address)

Behaviour:
- Reset: clk and rst as decided (rst synchronous, active-high). Both RR pointers = 0; rsp_valid = 0, rsp_id = 0. req_ready is combinational and is 0 while rst = 1.
- Read candidates = req_valid & ~req_we. Write candidates = req_valid & req_we.
- Round-robin per class: search starts at ptr, wraps NUM_REQ-1 -> 0, picks the first candidate.
  - On a grant, that class's ptr <= granted index + 1, mod NUM_REQ.
  - With no grant, ptr holds.
- req_ready[i] = 1 only for the granted read index and the granted write index.
  - Combinational from req_valid/req_we and ptr; never asserted without valid.
  - A requester not granted must hold its request stable until granted.
- Write grant: mem_wr_en = 1; mem_wr_addr/mem_wr_data = winner's fields, same cycle.
  - No write grant: mem_wr_en = 0, mem_wr_addr = 0, mem_wr_data = 0.
- Read grant: mem_rd_addr = winner's address, same cycle.
  - Next cycle: rsp_valid = 1, rsp_id = winner, rsp_data = mem_rd_data.
  - No read grant: mem_rd_addr = 0 and next-cycle rsp_valid = 0.
- rsp_data is a pass-through of mem_rd_data. Responses have no backpressure.
- Read latency is 1 cycle after acceptance; throughput is 1 read + 1 write per cycle.
- Same-address read and write granted in one cycle: the read returns the newly written data, because the memory forwards. The arbiter adds no hazard stall.
- A single requester cannot be granted read and write together; it presents only one type per cycle.
- rst asserted with a read in flight: the response is dropped (rsp_valid = 0 the next cycle).

Optional Feature:
- Macro: SYNC_MEM_PORT_ARB_PERF_CNT_EN.
- Defined:
  - Adds output perf_grant_cnt [NUM_REQ][16]: per-requester count of accepted requests (read or write).
  - Counters saturate at 0xFFFF and are cleared by rst.
  - Adds output perf_conflict_cnt [16]: cycles where more than one requester was denied within the same class; also saturating.
- Undefined: these ports and counters are absent. Functional behaviour is identical.

Decomposition:
- Package sync_mem_port_arb_pkg:
  - PERF_CNT_WIDTH = 16.
  - rsp_tag_t struct {valid, id}.
  - Function next_ptr(idx, n) implementing the wrap rule.
- Sub-module rr_arbiter:
  - Parameterised on NUM_REQ.
  - Inputs: req vector, advance. Outputs: one-hot grant, grant index. Owns its own pointer register.
  - Instantiated twice (read class, write class).

Test Plan:
- Reset, then req0 write addr 0x10 data 0xA5 -> req_ready[0] = 1 same cycle, mem_wr_en = 1, mem_wr_addr = 0x10, mem_wr_data = 0xA5. Then req1 read 0x10 -> next cycle rsp_valid = 1, rsp_id = 1, rsp_data = 0xA5.
- All 4 requesters read continuously from addresses 0x00..0x03 (preloaded 0x11..0x44) -> grants 0,1,2,3,0,… with one per cycle; rsp_id/rsp_data sequence 0/0x11, 1/0x22, 2/0x33, 3/0x44.
- Same cycle: req2 writes 0x20 = 0x5A and req3 reads 0x20 (old value 0x00) -> both granted; next cycle rsp_id = 3, rsp_data = 0x5A.
- req0 and req2 both write continuously for 6 cycles -> write grants alternate 0,2,0,2,0,2; no cycle has two write grants.
- Read granted, rst asserted the next cycle -> rsp_valid = 0, both pointers back to 0, and the first post-reset read grant goes to the lowest-index requester.
- With SYNC_MEM_PORT_ARB_PERF_CNT_EN defined: 70000 accepted requests from req1 -> perf_grant_cnt[1] = 0xFFFF, no wrap.
